// File: rtl/branch_hazard_ctrl_pkg.sv
// Shared types and constants for the branch/hazard control slice:
// FSM states, branch funct3 encodings and the branch-condition decode.
package branch_hazard_ctrl_pkg;

    localparam int unsigned WB_LAT_DEFAULT = 3;
    localparam int unsigned CNT_W_DEFAULT  = 32;
    localparam int unsigned REG_AW         = 5;
    localparam int unsigned NUM_REGS       = 32;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Signed and unsigned compares share one less-than result; the comparator mode picks the flavour.
    function automatic logic br_cond(input logic [2:0] f3, input logic less, input logic equal);
        logic r;
        r = 1'b0;
        case (f3)
            F3_BEQ:  r = equal;
            F3_BNE:  r = ~equal;
            F3_BLT:  r = less;
            F3_BGE:  r = ~less;
            F3_BLTU: r = less;
            F3_BGEU: r = ~less;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic br_f3_illegal(input logic [2:0] f3);
        return (f3 == 3'b010) || (f3 == 3'b011);
    endfunction

endpackage

// File: rtl/branch_hazard_ctrl_if.sv
// ID/EX control bundle between the pipeline datapath (master) and the hazard controller (slave).
interface branch_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    import branch_hazard_ctrl_pkg::*;

    logic             id_valid;
    logic [4:0]       id_rs1_addr;
    logic [4:0]       id_rs2_addr;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic [4:0]       id_rd_addr;
    logic             id_rd_wren;
    logic             ex_valid;
    logic             ex_is_branch;
    logic             ex_is_jump;
    logic [2:0]       ex_funct3;
    logic             br_less;
    logic             br_equal;

    logic             br_unsigned;
    logic             br_taken;
    logic             stall_pc;
    logic             stall_if_id;
    logic             bubble_id_ex;
    logic             flush_if_id;
    logic             id_issue;
    logic             br_illegal;
    state_e           state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
               id_rd_addr, id_rd_wren, ex_valid, ex_is_branch, ex_is_jump,
               ex_funct3, br_less, br_equal,
        input  br_unsigned, br_taken, stall_pc, stall_if_id, bubble_id_ex,
               flush_if_id, id_issue, br_illegal, state, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
               id_rd_addr, id_rd_wren, ex_valid, ex_is_branch, ex_is_jump,
               ex_funct3, br_less, br_equal,
        output br_unsigned, br_taken, stall_pc, stall_if_id, bubble_id_ex,
               flush_if_id, id_issue, br_illegal, state, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/branch_hazard_ctrl_scoreboard.sv
// Register busy scoreboard: one down-counter per architectural register, x0 never busy.
module hazard_scoreboard
    import branch_hazard_ctrl_pkg::*;
#(
    parameter int unsigned WB_LAT = WB_LAT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] i_rs1_addr,
    input  logic [REG_AW-1:0] i_rs2_addr,
    input  logic              i_load,
    input  logic [REG_AW-1:0] i_load_addr,
    output logic              o_rs1_busy,
    output logic              o_rs2_busy
);
    localparam int unsigned CW = (WB_LAT < 1) ? 1 : $clog2(WB_LAT + 1);

    logic [CW-1:0] r_cnt [NUM_REGS];

    // A new writer reloads the full latency even if the register is still counting down.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) r_cnt[i] <= '0;
        end else begin
            r_cnt[0] <= '0;
            for (int i = 1; i < NUM_REGS; i++) begin
                if (i_load && (i_load_addr == REG_AW'(i))) r_cnt[i] <= CW'(WB_LAT);
                else if (r_cnt[i] != '0)                   r_cnt[i] <= r_cnt[i] - CW'(1);
            end
        end
    end

    assign o_rs1_busy = (i_rs1_addr != '0) && (r_cnt[i_rs1_addr] != '0);
    assign o_rs2_busy = (i_rs2_addr != '0) && (r_cnt[i_rs2_addr] != '0);

endmodule

// File: rtl/branch_hazard_ctrl.sv
// Branch resolution and RAW hazard control: decides issue, stall, bubble and flush each cycle.
module branch_hazard_ctrl
    import branch_hazard_ctrl_pkg::*;
#(
    parameter int unsigned WB_LAT = WB_LAT_DEFAULT,
    parameter int unsigned CNT_W  = CNT_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_hazard_ctrl_if.slave  bus
);
    logic             w_rs1_busy;
    logic             w_rs2_busy;
    logic             w_cond;
    logic             w_taken;
    logic             w_hazard;
    logic             w_stall;
    logic             w_issue;
    logic             w_load;
    state_e           r_state;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    hazard_scoreboard #(.WB_LAT(WB_LAT)) u_sb (
        .clk         (clk),
        .rst         (rst),
        .i_rs1_addr  (bus.id_rs1_addr),
        .i_rs2_addr  (bus.id_rs2_addr),
        .i_load      (w_load),
        .i_load_addr (bus.id_rd_addr),
        .o_rs1_busy  (w_rs1_busy),
        .o_rs2_busy  (w_rs2_busy)
    );

    assign w_cond   = br_cond(bus.ex_funct3, bus.br_less, bus.br_equal);
    assign w_taken  = bus.ex_valid & (bus.ex_is_jump | (bus.ex_is_branch & w_cond));
    assign w_hazard = bus.id_valid & ((bus.id_rs1_used & w_rs1_busy) | (bus.id_rs2_used & w_rs2_busy));
    assign w_stall  = w_hazard & ~w_taken;
    // A taken branch kills the ID instruction, so it neither issues nor claims its rd.
    assign w_issue  = bus.id_valid & ~w_hazard & ~w_taken;
    assign w_load   = w_issue & bus.id_rd_wren & (bus.id_rd_addr != '0);

    assign bus.br_unsigned  = bus.ex_funct3[1];
    assign bus.br_taken     = w_taken;
    assign bus.br_illegal   = bus.ex_valid & bus.ex_is_branch & br_f3_illegal(bus.ex_funct3);
    assign bus.stall_pc     = w_stall;
    assign bus.stall_if_id  = w_stall;
    assign bus.bubble_id_ex = w_stall | w_taken;
    assign bus.flush_if_id  = w_taken;
    assign bus.id_issue     = w_issue;
    assign bus.state        = r_state;
    assign bus.stall_cnt    = r_stall_cnt;
    assign bus.flush_cnt    = r_flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_taken)       r_state <= ST_FLUSH;
            else if (w_hazard) r_state <= ST_STALL;
            else               r_state <= ST_RUN;
            if (w_stall) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_taken) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed bench for branch_hazard_ctrl: RAW stalls, branch flush priority, funct3 decode, reset.
module tb_branch_hazard_ctrl;
    import branch_hazard_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_err    = 0;
    int   exp_flush;

    always #5 clk = ~clk;

    branch_hazard_ctrl_if #(.CNT_W(32)) bus ();

    branch_hazard_ctrl #(.WB_LAT(3), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Order: {stall_pc, stall_if_id, bubble_id_ex, flush_if_id, id_issue}
    task automatic chk_ctrl(input string tag, input logic [4:0] exp);
        chk(tag, 32'({bus.stall_pc, bus.stall_if_id, bus.bubble_id_ex, bus.flush_if_id, bus.id_issue}), 32'(exp));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic id_set(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2, input logic [4:0] rd, input logic wr);
        bus.id_valid = v;   bus.id_rs1_addr = rs1; bus.id_rs1_used = u1;
        bus.id_rs2_addr = rs2; bus.id_rs2_used = u2;
        bus.id_rd_addr = rd; bus.id_rd_wren = wr;
    endtask

    task automatic ex_set(input logic v, input logic br, input logic jmp,
                          input logic [2:0] f3, input logic less, input logic eq);
        bus.ex_valid = v; bus.ex_is_branch = br; bus.ex_is_jump = jmp;
        bus.ex_funct3 = f3; bus.br_less = less; bus.br_equal = eq;
    endtask

    task automatic idle();
        id_set(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        ex_set(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    function automatic logic exp_taken(input logic [2:0] f, input logic l, input logic e);
        case (f)
            3'b000:  return e;
            3'b001:  return !e;
            3'b100:  return l;
            3'b101:  return !l;
            3'b110:  return l;
            3'b111:  return !l;
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        idle();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        #1;
        chk("rst_state", 32'(bus.state), 32'(ST_RUN));
        chk("rst_stall_cnt", bus.stall_cnt, 32'd0);
        chk("rst_flush_cnt", bus.flush_cnt, 32'd0);
        chk_ctrl("rst_ctrl", 5'b00000);

        // Writer x5 issues, dependent stalls three cycles
        id_set(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1); #1;
        chk_ctrl("x5_issue", 5'b00001);
        step(); id_set(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1); #1;
        chk_ctrl("raw_c1", 5'b11100);
        chk("raw_c1_state", 32'(bus.state), 32'(ST_RUN));
        step(); #1;
        chk_ctrl("raw_c2", 5'b11100);
        chk("raw_c2_state", 32'(bus.state), 32'(ST_STALL));
        step(); #1;
        chk_ctrl("raw_c3", 5'b11100);
        step(); #1;
        chk_ctrl("raw_c4_issue", 5'b00001);
        chk("raw_stall_cnt", bus.stall_cnt, 32'd3);
        step(); idle(); #1;
        chk("raw_c5_state", 32'(bus.state), 32'(ST_RUN));
        repeat (4) step();

        // Taken BLT beats a concurrent RAW hazard
        id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1); #1;
        chk_ctrl("x10_issue", 5'b00001);
        step();
        id_set(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        ex_set(1'b1, 1'b1, 1'b0, 3'b100, 1'b1, 1'b0); #1;
        chk("blt_taken", 32'(bus.br_taken), 32'd1);
        chk_ctrl("blt_ctrl", 5'b00110);
        step(); idle(); #1;
        chk("blt_state", 32'(bus.state), 32'(ST_FLUSH));
        chk("blt_flush_cnt", bus.flush_cnt, 32'd1);
        chk("blt_stall_cnt", bus.stall_cnt, 32'd3);
        repeat (4) step();

        // Jump kills an ID writer: its rd must not become busy
        ex_set(1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0);
        id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1); #1;
        chk_ctrl("jmp_kill", 5'b00110);
        step(); idle();
        id_set(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); #1;
        chk_ctrl("x12_not_busy", 5'b00001);
        chk("jmp_flush_cnt", bus.flush_cnt, 32'd2);
        step(); idle();

        // funct3 x (less, equal) sweep
        exp_flush = 2;
        for (int f3 = 0; f3 < 8; f3++) begin
            for (int c = 0; c < 4; c++) begin
                ex_set(1'b1, 1'b1, 1'b0, 3'(f3), c[1], c[0]); #1;
                chk($sformatf("f3_%0d_c%0d_taken", f3, c), 32'(bus.br_taken),
                    32'(exp_taken(3'(f3), c[1], c[0])));
                chk($sformatf("f3_%0d_c%0d_unsigned", f3, c), 32'(bus.br_unsigned), 32'((f3 >> 1) & 1));
                chk($sformatf("f3_%0d_c%0d_illegal", f3, c), 32'(bus.br_illegal),
                    32'((f3 == 2 || f3 == 3) ? 1 : 0));
                if (exp_taken(3'(f3), c[1], c[0])) exp_flush++;
                step();
            end
        end
        idle(); #1;
        chk("sweep_flush_cnt", bus.flush_cnt, 32'(exp_flush));

        // x0 is never busy
        step(); id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1); #1;
        chk_ctrl("x0_write", 5'b00001);
        step(); id_set(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0); #1;
        chk_ctrl("x0_read", 5'b00001);

        // Re-issue x7 while its counter is 1
        step(); id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1); #1;
        chk_ctrl("x7_first", 5'b00001);
        step(); idle();
        step();
        step(); id_set(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1); #1;
        chk_ctrl("x7_reissue", 5'b00001);
        step(); id_set(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0); #1;
        chk_ctrl("x7_busy1", 5'b11100);
        step(); #1;
        chk_ctrl("x7_busy2", 5'b11100);
        step(); #1;
        chk_ctrl("x7_busy3", 5'b11100);
        step(); #1;
        chk_ctrl("x7_free", 5'b00001);
        chk("x7_stall_cnt", bus.stall_cnt, 32'd6);
        step(); idle();

        // Reset in the middle of a stall on x9
        step(); id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1); #1;
        chk_ctrl("x9_issue", 5'b00001);
        step(); id_set(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); #1;
        chk_ctrl("x9_stall", 5'b11100);
        step(); #1;
        chk("x9_state_stall", 32'(bus.state), 32'(ST_STALL));
        rst = 1'b1;
        step();
        rst = 1'b0; #1;
        chk("post_rst_state", 32'(bus.state), 32'(ST_RUN));
        chk("post_rst_stall_cnt", bus.stall_cnt, 32'd0);
        chk("post_rst_flush_cnt", bus.flush_cnt, 32'd0);
        chk_ctrl("post_rst_x9_free", 5'b00001);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
